// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared synchronous memory port.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX data wins.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetb,

  input  logic        im_req,
  input  logic [31:0] im_addr,
  output logic        im_gnt,
  output logic        im_rvalid,
  output logic [31:0] im_rdata,

  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,

  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;
  logic          owner;
  logic          pend;
  logic          fetch_wins;

  always_comb begin
    fetch_wins = im_req && (!dm_req || (starve_cnt == SMAX));
    im_gnt     = !resetb && fetch_wins;
    dm_gnt     = !resetb && dm_req && !fetch_wins;
    mem_en     = im_gnt || dm_gnt;
    mem_we     = dm_gnt && dm_we;
    mem_be     = 4'b0000;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    if (dm_gnt) begin
      mem_be    = dm_be;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (im_gnt) begin
      mem_be    = 4'b1111;
      mem_addr  = im_addr;
    end
  end

  // Gating with resetb drops a response whose reset arrives right behind the grant.
  assign im_rvalid = pend && !owner && !resetb;
  assign dm_rvalid = pend &&  owner && !resetb;
  assign im_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

  always_ff @(posedge clk) begin
    if (resetb) begin
      starve_cnt <= '0;
      owner      <= 1'b0;
      pend       <= 1'b0;
    end else begin
      pend <= mem_en;
      if (mem_en) begin
        owner <= dm_gnt;
      end
      if (!im_req || im_gnt) begin
        starve_cnt <= '0;
      end else if (dm_gnt && (starve_cnt != SMAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Parameters
REQ-001 The block SHALL have parameter STARVE_MAX, default 4, meaning the maximum consecutive data grants issued while a fetch request waits.

Interface
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetb  input  1  reset: synchronous, active-high (resetb=1 resets at the next rising clk edge).
REQ-004 The block SHALL have port im_req  input  1  fetch port read request.
REQ-005 The block SHALL have port im_addr  input  32  fetch word address.
REQ-006 The block SHALL have port im_gnt  output  1  fetch request accepted this cycle.
REQ-007 The block SHALL have port im_rvalid  output  1  fetch read data valid.
REQ-008 The block SHALL have port im_rdata  output  32  fetch read data.
REQ-009 The block SHALL have port dm_req  input  1  data port request.
REQ-010 The block SHALL have port dm_we  input  1  data write enable.
REQ-011 The block SHALL have port dm_be  input  4  data byte enables.
REQ-012 The block SHALL have port dm_addr  input  32  data address.
REQ-013 The block SHALL have port dm_wdata  input  32  data write value.
REQ-014 The block SHALL have port dm_gnt  output  1  data request accepted this cycle.
REQ-015 The block SHALL have port dm_rvalid  output  1  data access complete; read data valid for reads, acknowledge only for writes.
REQ-016 The block SHALL have port dm_rdata  output  32  data read data.
REQ-017 The block SHALL have ports mem_en, mem_we (output, 1), mem_be (output, 4), mem_addr and mem_wdata (output, 32): the single shared synchronous memory port.
REQ-018 The block SHALL have port mem_rdata  input  32  memory read data, valid one cycle after the cycle with mem_en=1.

Function
REQ-019 Grant SHALL be combinational in the request cycle: at most one of im_gnt and dm_gnt SHALL be 1 per cycle, and the granted port's signals SHALL drive mem_*.
REQ-020 mem_en SHALL equal im_gnt OR dm_gnt; mem_we SHALL equal dm_gnt AND dm_we; for fetches mem_be SHALL be 4'b1111 and mem_we SHALL be 0.
REQ-021 Priority SHALL be data over fetch, except when starve_cnt equals STARVE_MAX and im_req=1; in that case fetch SHALL win.
REQ-022 starve_cnt SHALL increment, saturating at STARVE_MAX, on each cycle with dm_gnt=1 and im_req=1; it SHALL clear on im_gnt=1 and on any cycle with im_req=0.
REQ-023 A one-bit owner register SHALL record the granted port (0 = fetch, 1 = data), and a pend register SHALL record mem_en.
REQ-024 In the cycle after a grant, the owner's rvalid SHALL be 1 and the other port's rvalid SHALL be 0; rvalid SHALL last exactly one cycle per grant.
REQ-025 im_rdata and dm_rdata SHALL both pass mem_rdata combinationally; they are meaningful only while the matching rvalid is 1.
REQ-026 Back-to-back grants SHALL be supported with throughput of 1 access per cycle and latency of 1 cycle, independent of the owner switching.
REQ-027 A requester SHALL hold its req and request signals stable until it receives gnt; a request without gnt SHALL have no effect on memory.
REQ-028 In a cycle with no requests, mem_en SHALL be 0; mem_addr, mem_wdata and mem_be are don't-care but SHALL NOT be X (drive the last-granted or zero values).

Reset
REQ-029 While resetb=1, im_gnt, dm_gnt, mem_en and mem_we SHALL be forced to 0, regardless of the req inputs.
REQ-030 After a reset edge, im_rvalid=0, dm_rvalid=0, starve_cnt=0, owner=0 and pend=0.
REQ-031 An access granted in the cycle before a reset edge SHALL have its rvalid suppressed; there SHALL be no rvalid in the first cycle after reset.

Verification
REQ-032 The bench SHALL cover this scenario: im_req=1 only, im_addr=0x100, mem returns 0xDEADBEEF -> im_gnt=1 in cycle 0, then im_rvalid=1 and im_rdata=0xDEADBEEF in cycle 1, dm_rvalid=0.
REQ-033 The bench SHALL cover this scenario: im_req and dm_req both 1 in the same cycle, dm_we=0 -> dm_gnt=1, im_gnt=0, and mem_addr=dm_addr.
REQ-034 The bench SHALL cover this scenario: im_req and dm_req both held 1 continuously with STARVE_MAX=4 -> data granted for cycles 0-3, fetch in cycle 4, data again from cycle 5.
REQ-035 The bench SHALL cover this scenario: dm write with dm_be=4'b0011 and data 0x12345678 -> mem_we=1, mem_be=4'b0011, mem_wdata=0x12345678, and dm_rvalid=1 in the next cycle.
REQ-036 The bench SHALL cover this scenario: a fetch is granted, then resetb=1 at the next edge -> im_rvalid stays 0, and all grants are 0 while resetb=1 even with both req=1.
REQ-037 The bench SHALL cover this scenario: alternating fetch/data grants in consecutive cycles -> each rvalid is routed to the correct owner with no gap cycles.
